// File: rtl/attn_pkg.sv
// Shared constants, FSM state type and 16-bit saturation helper for the attention tile.
package attn_pkg;
    localparam int WIDTH = 8;
    localparam int K_DIM = 4;
    localparam int FRAC  = 4;
    localparam int RW    = 2 * WIDTH;
    // Two guard bits: enough headroom for the sum of four RW-bit values.
    localparam int SW    = RW + 2;

    typedef enum logic [1:0] {IDLE, MAC, SUM, DONE} state_t;

    localparam logic signed [SW-1:0] SAT_MAX = SW'(2**(RW-1) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2**(RW-1)));

    function automatic logic signed [RW-1:0] sat16(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[RW-1:0];
        else if (v < SAT_MIN) return SAT_MIN[RW-1:0];
        return v[RW-1:0];
    endfunction
endpackage

// File: rtl/mini_pe.sv
// Single MAC element: signed multiply, optional fixed-point rescale, saturating accumulate.
module mini_pe
    import attn_pkg::*;
(
    input  logic                    clk,
    input  logic                    _reset,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    int_mul,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [RW-1:0]    acc
);
    logic signed [RW-1:0] prod;
    logic signed [RW-1:0] term;
    logic signed [RW:0]   sum;

    assign prod = a * b;
    assign term = int_mul ? prod : (prod >>> FRAC);
    assign sum  = acc + term;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset)    acc <= '0;
        else if (clear) acc <= '0;
        else if (en)    acc <= sat16(SW'(sum));
    end
endmodule

// File: rtl/mini_pe_array.sv
// 2x4 * 4x2 signed matrix tile: four PEs sweep K one step per clock, then a saturated importance sum.
module mini_pe_array
    import attn_pkg::*;
(
    input  logic              clk,
    input  logic              _reset,
    input  logic              enable,
    input  logic              intMul,
    input  logic [WIDTH-1:0]  a00, a01, a02, a03,
    input  logic [WIDTH-1:0]  a10, a11, a12, a13,
    input  logic [WIDTH-1:0]  b1_00, b1_10, b1_20, b1_30,
    input  logic [WIDTH-1:0]  b1_01, b1_11, b1_21, b1_31,
    output logic [RW-1:0]     result0,
    output logic [RW-1:0]     result1,
    output logic [RW-1:0]     result2,
    output logic [RW-1:0]     result3,
    output logic [RW-1:0]     importance,
    output logic              done
);
    localparam int NUM_PE = 4;

    state_t                           state;
    logic [1:0]                       k;
    logic                             int_mul_q;
    logic [1:0][K_DIM-1:0][WIDTH-1:0] a_in, b_in, a_cap, b_cap;
    logic [NUM_PE-1:0][RW-1:0]        acc;
    logic signed [SW-1:0]             imp_sum;
    logic                             clear, mac_en;

    assign a_in[0] = {a03, a02, a01, a00};
    assign a_in[1] = {a13, a12, a11, a10};
    assign b_in[0] = {b1_30, b1_20, b1_10, b1_00};
    assign b_in[1] = {b1_31, b1_21, b1_11, b1_01};

    assign clear  = (state == IDLE) && enable;
    assign mac_en = (state == MAC);

    // PE i computes C[i/2][i%2]
    for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
        localparam int R = i / 2;
        localparam int C = i % 2;
        mini_pe u_pe (
            .clk     (clk),
            ._reset  (_reset),
            .clear   (clear),
            .en      (mac_en),
            .int_mul (int_mul_q),
            .a       (a_cap[R][k]),
            .b       (b_cap[C][k]),
            .acc     (acc[i])
        );
    end

    always_comb begin
        imp_sum = '0;
        for (int i = 0; i < NUM_PE; i++)
            imp_sum = imp_sum + SW'(signed'(acc[i]));
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state      <= IDLE;
            k          <= '0;
            int_mul_q  <= 1'b0;
            a_cap      <= '0;
            b_cap      <= '0;
            importance <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    a_cap     <= a_in;
                    b_cap     <= b_in;
                    int_mul_q <= intMul;
                    k         <= '0;
                    state     <= MAC;
                end
                MAC: begin
                    k <= k + 2'd1;
                    if (k == 2'(K_DIM - 1)) state <= SUM;
                end
                SUM: begin
                    importance <= sat16(imp_sum);
                    done       <= 1'b1;
                    state      <= DONE;
                end
                DONE: if (!enable) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign result0 = acc[0];
    assign result1 = acc[1];
    assign result2 = acc[2];
    assign result3 = acc[3];
endmodule

// File: tb/tb_mini_pe_array.sv
// Randomized bench for mini_pe_array with an arithmetic reference model and directed literal checks.
module tb_mini_pe_array;
    logic clk = 1'b0;
    logic rst_n, enable, intMul;
    logic signed [7:0] ta [2][4];   // A rows
    logic signed [7:0] tb [2][4];   // B columns
    logic signed [15:0] result0, result1, result2, result3, importance;
    logic done;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 0;

    always #5 clk = ~clk;

    mini_pe_array dut (
        .clk(clk), ._reset(rst_n), .enable(enable), .intMul(intMul),
        .a00(ta[0][0]), .a01(ta[0][1]), .a02(ta[0][2]), .a03(ta[0][3]),
        .a10(ta[1][0]), .a11(ta[1][1]), .a12(ta[1][2]), .a13(ta[1][3]),
        .b1_00(tb[0][0]), .b1_10(tb[0][1]), .b1_20(tb[0][2]), .b1_30(tb[0][3]),
        .b1_01(tb[1][0]), .b1_11(tb[1][1]), .b1_21(tb[1][2]), .b1_31(tb[1][3]),
        .result0(result0), .result1(result1), .result2(result2), .result3(result3),
        .importance(importance), .done(done)
    );

    function automatic int sat(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int prod(int a, int b, bit im);
        return im ? a * b : (a * b) >>> 4;
    endfunction

    function automatic int get_res(int i);
        case (i)
            0: return int'(result0);
            1: return int'(result1);
            2: return int'(result2);
            default: return int'(result3);
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: m_edges counts clock edges since the start edge
    // (0 = not running, 1..4 = next MAC step, 5 = summing, 6 = results held).
    int m_a [2][4];
    int m_b [2][4];
    bit m_int = 0;
    int m_res [4] = '{0, 0, 0, 0};
    int m_imp = 0;
    bit m_done = 0;
    int m_edges = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_res[i]) m_res[i] = 0;
            m_imp = 0; m_done = 0; m_edges = 0;
        end else if (m_edges == 0) begin
            if (enable) begin
                for (int r = 0; r < 2; r++)
                    for (int k = 0; k < 4; k++) begin
                        m_a[r][k] = int'(ta[r][k]);
                        m_b[r][k] = int'(tb[r][k]);
                    end
                m_int = intMul;
                foreach (m_res[i]) m_res[i] = 0;
                m_edges = 1;
            end
        end else if (m_edges <= 4) begin
            for (int i = 0; i < 4; i++)
                m_res[i] = sat(m_res[i] + prod(m_a[i/2][m_edges-1], m_b[i%2][m_edges-1], m_int));
            m_edges++;
        end else if (m_edges == 5) begin
            m_imp = sat(m_res[0] + m_res[1] + m_res[2] + m_res[3]);
            m_done = 1;
            m_edges = 6;
        end else if (!enable) begin
            m_done = 0;
            m_edges = 0;
        end
    end

    always @(negedge clk) begin
        if (run_cmp && rst_n === 1'b1) begin
            for (int i = 0; i < 4; i++) chk($sformatf("result%0d", i), get_res(i), m_res[i]);
            chk("importance", int'(importance), m_imp);
            chk("done", int'(done), int'(m_done));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_ops(int a0, int a1, int b0, int b1);
        for (int k = 0; k < 4; k++) begin
            ta[0][k] = 8'(a0); ta[1][k] = 8'(a1);
            tb[0][k] = 8'(b0); tb[1][k] = 8'(b1);
        end
    endtask

    task automatic scramble();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) begin
                ta[r][k] = 8'($urandom_range(0, 255));
                tb[r][k] = 8'($urandom_range(0, 255));
            end
        intMul = 1'($urandom_range(0, 1));
    endtask

    // Raise enable, wait (bounded) for done, and pin the start-to-done latency.
    task automatic do_start(bit im, bit scr);
        int n = 0;
        @(negedge clk);
        intMul = im;
        enable = 1'b1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (scr && done !== 1'b1) scramble();
        end
        chk("latency", n, 6);
    endtask

    task automatic finish_op();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("done_drop", int'(done), 0);
    endtask

    task automatic chk_lits(int e0, int e1, int e2, int e3, int ei);
        chk("lit_r0", int'(result0), e0);
        chk("lit_r1", int'(result1), e1);
        chk("lit_r2", int'(result2), e2);
        chk("lit_r3", int'(result3), e3);
        chk("lit_imp", int'(importance), ei);
    endtask

    task automatic set_mixed();
        int a0v [4] = '{1, -2, 3, -4};
        int b0v [4] = '{5, 6, 7, 8};
        for (int k = 0; k < 4; k++) begin
            ta[0][k] = 8'(a0v[k]); ta[1][k] = -8'sd1;
            tb[0][k] = 8'(b0v[k]); tb[1][k] = -8'sd1;
        end
    endtask

    initial begin
        enable = 1'b0; intMul = 1'b1;
        set_ops(0, 0, 0, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_lits(0, 0, 0, 0, 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;
        run_cmp = 1;

        // basic
        set_ops(1, 0, 1, 1);
        do_start(1'b1, 1'b0);
        chk_lits(4, 4, 0, 0, 8);
        finish_op();

        // signed mixed
        set_mixed();
        do_start(1'b1, 1'b1);
        chk_lits(-18, 2, -26, 4, -38);
        finish_op();

        // saturation
        set_ops(-128, -128, -128, -128);
        do_start(1'b1, 1'b0);
        chk_lits(32767, 32767, 32767, 32767, 32767);
        finish_op();

        // fixed point, then hold with changing inputs
        set_ops(16, 16, 24, 24);
        do_start(1'b0, 1'b0);
        chk_lits(96, 96, 96, 96, 384);
        repeat (4) begin
            @(negedge clk);
            scramble();
        end
        @(negedge clk);
        chk_lits(96, 96, 96, 96, 384);
        chk("hold_done", int'(done), 1);
        finish_op();
        chk_lits(96, 96, 96, 96, 384);

        // restart
        set_ops(1, 0, 1, 1);
        do_start(1'b1, 1'b0);
        chk_lits(4, 4, 0, 0, 8);
        finish_op();

        // reset mid-MAC at k=2
        set_mixed();
        @(negedge clk);
        intMul = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("partial_r0", int'(result0), -7);
        #2 rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk_lits(0, 0, 0, 0, 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1'b1, 1'b0);
        chk_lits(-18, 2, -26, 4, -38);
        finish_op();

        // randomized transactions, with extremes mixed in for saturation
        for (int t = 0; t < 30; t++) begin
            for (int r = 0; r < 2; r++)
                for (int k = 0; k < 4; k++) begin
                    int s = $urandom_range(0, 3);
                    ta[r][k] = (s == 0) ? -8'sd128 : (s == 1) ? 8'sd127 : 8'($urandom_range(0, 255));
                    s = $urandom_range(0, 3);
                    tb[r][k] = (s == 0) ? -8'sd128 : (s == 1) ? 8'sd127 : 8'($urandom_range(0, 255));
                end
            do_start(1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                scramble();
            end
            finish_op();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
